tt3_sweep_ctrl: RTL and testbench

- Sequencer that characterises one external 3-input combinational logic gate against an 8-bit expected truth table.
- Drives all 8 input combinations onto the gate and waits a programmable settle time per vector.
- Samples the gate output for each vector, builds the measured truth table, and reports pass/fail plus a per-row mismatch mask.
- Sits between a host/config interface and a 3-input gate instance. The gate itself is outside this block.

---
 rtl/tt3_pkg.sv | 34 +++
 rtl/tt3_settle_timer.sv | 48 ++++
 rtl/tt3_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_tt3_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt3_pkg
// Description : Shared types and constants for the 3-input gate truth-table
//               sweep controller: FSM state encoding, Gray sweep order,
//               truth-table width and the row-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tt3_pkg;

    // Width of a 3-input truth table (one bit per input combination).
    localparam int TT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Gray sweep order; entry 0 is the leftmost element.
    localparam logic [0:7][2:0] GRAY_SEQ = {
        3'b000, 3'b001, 3'b011, 3'b010,
        3'b110, 3'b111, 3'b101, 3'b100
    };

    // Tables are stored MSB-first: input vector idx lives in bit (7 - idx).
    function automatic logic [2:0] row_bit(input logic [2:0] idx);
        return 3'd7 - idx;
    endfunction

endpackage : tt3_pkg
`default_nettype wire

// File: rtl/tt3_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tt3_settle_timer
// Description : Loadable, saturating down-counter used to hold each vector on
//               the gate for the configured settle time.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_load          - load i_load_val (has priority over i_en)
//               i_load_val      - value to load
//               i_en            - decrement by one when non-zero
//               o_zero          - counter value is zero
// Revision    : 1.0 - initial release
// ============================================================================
module tt3_settle_timer #(
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [SETTLE_W-1:0] i_load_val,
    input  logic                i_en,
    output logic                o_zero
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en && (cnt_q != '0)) begin
            // Saturate at zero so the counter never wraps.
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule : tt3_settle_timer
`default_nettype wire

// File: rtl/tt3_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tt3_sweep_ctrl
// Description : Drives all 8 input combinations onto an external 3-input gate,
//               waits a programmable settle time per vector, samples the gate
//               output and compares the measured truth table to the expected.
// Ports       : clk, rst_n      - clock, async active-low reset
//               start, abort    - begin sweep / terminate sweep in progress
//               cfg_expected    - expected truth table (bit 7-idx = row idx)
//               cfg_settle      - settle cycles per vector
//               dut_out         - gate output (synchronous to clk)
//               drive_in        - {in1,in2,in3} to the gate
//               drive_valid     - vector being held on the gate
//               busy, done      - sweep in progress / completion pulse
//               pass            - measured == expected (valid from done)
//               measured        - captured truth table
//               mismatch        - measured ^ expected
// Revision    : 1.0 - initial release
// ============================================================================
module tt3_sweep_ctrl
    import tt3_pkg::*;
#(
    parameter int SETTLE_W   = 8,
    parameter bit GRAY_ORDER = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [TT_W-1:0]     cfg_expected,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic                dut_out,
    output logic [2:0]          drive_in,
    output logic                drive_valid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [TT_W-1:0]     measured,
    output logic [TT_W-1:0]     mismatch
);

    state_t              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic [TT_W-1:0]     exp_q, exp_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [TT_W-1:0]     measured_q, measured_d;
    logic [TT_W-1:0]     mismatch_q, mismatch_d;
    logic                pass_q, pass_d;
    logic [2:0]          drive_in_q, drive_in_d;

    logic                w_tmr_load;
    logic                w_tmr_en;
    logic                w_tmr_zero;
    logic                w_abort_busy;

    function automatic logic [2:0] vec_of(input logic [2:0] step);
        if (GRAY_ORDER) begin
            return GRAY_SEQ[step];
        end else begin
            return step;
        end
    endfunction

    assign w_abort_busy = abort && (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Settle timer: loaded with settle-1 during APPLY so that SETTLE lasts
    // exactly 'settle' cycles (exit on the cycle the counter reads zero).
    // ------------------------------------------------------------------
    assign w_tmr_load = (state_q == ST_APPLY);
    assign w_tmr_en   = (state_q == ST_SETTLE);

    tt3_settle_timer #(
        .SETTLE_W (SETTLE_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (settle_q - SETTLE_W'(1)),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (abort has priority in every busy state, and also
    // beats a simultaneous start in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && !abort) state_d = ST_APPLY;
            ST_APPLY:  state_d = (settle_q == '0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (w_tmr_zero) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (step_q == 3'd7) ? ST_DONE : ST_APPLY;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (w_abort_busy) begin
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != ST_IDLE);
        drive_valid = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        step_d     = step_q;
        exp_d      = exp_q;
        settle_d   = settle_q;
        measured_d = measured_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        drive_in_d = drive_in_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    exp_d      = cfg_expected;
                    settle_d   = cfg_settle;
                    measured_d = '0;
                    mismatch_d = '0;
                    pass_d     = 1'b0;
                    step_d     = 3'd0;
                    // Present vector 0 on the same edge APPLY is entered.
                    drive_in_d = vec_of(3'd0);
                end
            end
            ST_SAMPLE: begin
                if (!abort) begin
                    measured_d[row_bit(vec_of(step_q))] = dut_out;
                    if (step_q == 3'd7) begin
                        // Result registered on entry to DONE so it is
                        // already valid during the done pulse.
                        mismatch_d = measured_d ^ exp_q;
                        pass_d     = (mismatch_d == '0);
                    end else begin
                        step_d     = step_q + 3'd1;
                        drive_in_d = vec_of(step_q + 3'd1);
                    end
                end
            end
            default: ;
        endcase

        if (w_abort_busy) begin
            pass_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q     <= 3'd0;
            exp_q      <= '0;
            settle_q   <= '0;
            measured_q <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            drive_in_q <= 3'd0;
        end else begin
            step_q     <= step_d;
            exp_q      <= exp_d;
            settle_q   <= settle_d;
            measured_q <= measured_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            drive_in_q <= drive_in_d;
        end
    end

    assign drive_in = drive_in_q;
    assign pass     = pass_q;
    assign measured = measured_q;
    assign mismatch = mismatch_q;

endmodule : tt3_sweep_ctrl
`default_nettype wire

// File: tb/tb_tt3_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt3_sweep_ctrl
// Description : Self-checking bench for tt3_sweep_ctrl with a behavioural
//               3-input LUT as the gate under control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt3_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_expected = 8'h00;
    logic [7:0] cfg_settle = 8'h00;
    logic       dut_out;
    logic [2:0] drive_in;
    logic       drive_valid;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] measured;
    logic [7:0] mismatch;

    int checks = 0;
    int failures = 0;

    // Gate model: LUT with table bit (7-idx) for input idx, or a "slow" gate
    // whose output only rises after a vector has been held for 2 cycles.
    logic [7:0] gate_tbl = 8'h00;
    logic       gate_slow = 1'b0;
    logic [2:0] last_drv = 3'b000;
    int         age = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drive_in !== last_drv) begin
            last_drv = drive_in;
            age = 0;
        end else if (age < 100) begin
            age = age + 1;
        end
    end

    always_comb begin
        dut_out = 1'b0;
        if (gate_slow) dut_out = (age >= 2);
        else           dut_out = gate_tbl[3'(7 - drive_in)];
    end

    tt3_sweep_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_expected (cfg_expected),
        .cfg_settle   (cfg_settle),
        .dut_out      (dut_out),
        .drive_in     (drive_in),
        .drive_valid  (drive_valid),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .measured     (measured),
        .mismatch     (mismatch)
    );

    logic [2:0] gray_ref [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};

    typedef struct {
        logic [7:0] gate;
        logic       slow;
        logic [7:0] cfg;
        logic [7:0] settle;
        int         dist_at;
        int         abort_at;
        int         exp_busy;
        int         exp_done;
        int         exp_nvec;
        logic [7:0] exp_meas;
        logic [7:0] exp_mm;
        logic       exp_pass;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " drive_in"},    32'(drive_in),    32'h0);
        check({tag, " drive_valid"}, 32'(drive_valid), 32'h0);
        check({tag, " busy"},        32'(busy),        32'h0);
        check({tag, " done"},        32'(done),        32'h0);
        check({tag, " pass"},        32'(pass),        32'h0);
        check({tag, " measured"},    32'(measured),    32'h0);
        check({tag, " mismatch"},    32'(mismatch),    32'h0);
    endtask

    task automatic run_sweep(input int idx, input vec_t r);
        int         k;
        int         done_cnt;
        int         nvec;
        int         seq_err;
        logic [2:0] seen;
        string      t;
        t = $sformatf("r%0d", idx);
        gate_tbl  = r.gate;
        gate_slow = r.slow;
        @(negedge clk);
        cfg_expected = r.cfg;
        cfg_settle   = r.settle;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; done_cnt = 0; nvec = 0; seq_err = 0; seen = 3'b000;
        while (busy === 1'b1 && k < 5000) begin
            k++;
            start = 1'b0;
            abort = 1'b0;
            if (done === 1'b1) done_cnt++;
            if (drive_valid === 1'b1 && (nvec == 0 || drive_in !== seen)) begin
                if (nvec < 8 && drive_in !== gray_ref[nvec]) seq_err++;
                seen = drive_in;
                nvec++;
            end
            if (k == r.dist_at) begin
                start = 1'b1;
                cfg_expected = ~r.cfg;
                cfg_settle = 8'd0;
            end
            if (k == r.abort_at) abort = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        check({t, " sweep_timeout"}, 32'(busy),     32'h0);
        check({t, " busy_cycles"},   32'(k),        32'(r.exp_busy));
        check({t, " done_pulses"},   32'(done_cnt), 32'(r.exp_done));
        check({t, " vec_count"},     32'(nvec),     32'(r.exp_nvec));
        check({t, " gray_order"},    32'(seq_err),  32'h0);
        check({t, " measured"},      32'(measured), 32'(r.exp_meas));
        check({t, " mismatch"},      32'(mismatch), 32'(r.exp_mm));
        check({t, " pass"},          32'(pass),     32'(r.exp_pass));
        check({t, " drive_valid_idle"}, 32'(drive_valid), 32'h0);
    endtask

    initial begin
        //           gate  slow cfg    settle dist abort busy done nvec meas   mm     pass
        vecs[0] = '{8'hDA, 1'b0, 8'hDA, 8'd3,   0,   0,  41,   1,   8, 8'hDA, 8'h00, 1'b1};
        vecs[1] = '{8'hDA, 1'b0, 8'hDB, 8'd0,   0,   0,  17,   1,   8, 8'hDA, 8'h01, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 8'hFF, 8'd0,   0,   0,  17,   1,   8, 8'h00, 8'hFF, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 8'hFF, 8'd2,   0,   0,  33,   1,   8, 8'hFF, 8'h00, 1'b1};
        vecs[4] = '{8'h96, 1'b0, 8'h69, 8'd1,   0,   0,  25,   1,   8, 8'h96, 8'hFF, 1'b0};
        vecs[5] = '{8'hDA, 1'b0, 8'hDA, 8'd3,  17,   0,  41,   1,   8, 8'hDA, 8'h00, 1'b1};
        vecs[6] = '{8'hDA, 1'b0, 8'hDA, 8'd3,   0,  22,  22,   0,   5, 8'hD0, 8'h00, 1'b0};
        vecs[7] = '{8'h3C, 1'b0, 8'h3C, 8'd255, 0,   0, 2057,  1,   8, 8'h3C, 8'h00, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_sweep(i, vecs[i]);
        end

        // abort alone in IDLE: results of the last sweep untouched
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort busy",     32'(busy),     32'h0);
        check("idle_abort pass",     32'(pass),     32'h1);
        check("idle_abort measured", 32'(measured), 32'h3C);

        // start and abort together in IDLE: abort wins, nothing cleared
        start = 1'b1;
        abort = 1'b1;
        cfg_expected = 8'h00;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort busy",     32'(busy),     32'h0);
        @(negedge clk);
        check("start_abort busy2",    32'(busy),     32'h0);
        check("start_abort measured", 32'(measured), 32'h3C);
        check("start_abort pass",     32'(pass),     32'h1);

        // Asynchronous reset during SAMPLE of step 1 (busy cycle 10)
        gate_tbl  = 8'hDA;
        gate_slow = 1'b0;
        cfg_expected = 8'hDA;
        cfg_settle   = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        check("pre_rst busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        check_reset_vals("mid_rst_hold");
        rst_n = 1'b1;
        run_sweep(8, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tt3_sweep_ctrl
`default_nettype wire
